// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants and the operand forward-select encoding used
// by the ID/EX operand stage.
package mips_pipe_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// One source operand: picks register-file, MEM, WB or hard zero, with MEM
// taking precedence over WB since it holds the younger result.
module operand_fwd_mux
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0]  src_reg_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_W-1:0]  mem_dst_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_W-1:0]  wb_dst_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (src_reg_i == REG_ZERO) begin
            sel = FWD_ZERO;
        end else if (mem_reg_write_i && (mem_dst_i == src_reg_i)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write_i && (wb_dst_i == src_reg_i)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_data_o = rf_data_i;
        unique case (sel)
            FWD_ZERO: fwd_data_o = '0;
            FWD_MEM:  fwd_data_o = mem_data_i;
            FWD_WB:   fwd_data_o = wb_data_i;
            default:  fwd_data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_operand_stage
    import mips_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_use_imm,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic [REG_W-1:0]       id_dst,
    input  logic [DATA_W-1:0]      id_imm,
    output logic [REG_W-1:0]       rf_raddr1,
    output logic [REG_W-1:0]       rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic                   mem_reg_write,
    input  logic [REG_W-1:0]       mem_dst,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   wb_reg_write,
    input  logic [REG_W-1:0]       wb_dst,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   ex_flush,
    input  logic                   ex_hold,
    output logic                   ex_valid,
    output logic [DATA_W-1:0]      ex_op_a,
    output logic [DATA_W-1:0]      ex_op_b,
    output logic [DATA_W-1:0]      ex_store_data,
    output logic [REG_W-1:0]       ex_dst,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   id_stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]      ex_op_a_q, ex_op_a_d;
    logic [DATA_W-1:0]      ex_op_b_q, ex_op_b_d;
    logic [DATA_W-1:0]      ex_store_data_q, ex_store_data_d;
    logic [REG_W-1:0]       ex_dst_q, ex_dst_d;
    logic                   ex_reg_write_q, ex_reg_write_d;
    logic                   ex_mem_read_q, ex_mem_read_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;
    logic              load_use;

    assign rf_raddr1 = id_rs;
    assign rf_raddr2 = id_rt;

    operand_fwd_mux u_fwd_rs (
        .src_reg_i       (id_rs),
        .rf_data_i       (rf_rdata1),
        .mem_reg_write_i (mem_reg_write),
        .mem_dst_i       (mem_dst),
        .mem_data_i      (mem_data),
        .wb_reg_write_i  (wb_reg_write),
        .wb_dst_i        (wb_dst),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rs_value)
    );

    operand_fwd_mux u_fwd_rt (
        .src_reg_i       (id_rt),
        .rf_data_i       (rf_rdata2),
        .mem_reg_write_i (mem_reg_write),
        .mem_dst_i       (mem_dst),
        .mem_data_i      (mem_data),
        .wb_reg_write_i  (wb_reg_write),
        .wb_dst_i        (wb_dst),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rt_value)
    );

    // A load still in EX cannot be forwarded yet; one bubble lets it reach MEM.
    assign load_use = ex_valid_q && ex_mem_read_q && (ex_dst_q != REG_ZERO) && id_valid
                      && ((ex_dst_q == id_rs) || (ex_dst_q == id_rt));
    assign id_stall = load_use || ex_hold;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_op_a_d       = ex_op_a_q;
        ex_op_b_d       = ex_op_b_q;
        ex_store_data_d = ex_store_data_q;
        ex_dst_d        = ex_dst_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        stall_count_d   = stall_count_q;
        if (ex_flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (load_use) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            if (stall_count_q != '1) begin
                stall_count_d = stall_count_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ex_valid_d      = id_valid;
            ex_op_a_d       = rs_value;
            ex_op_b_d       = id_use_imm ? id_imm : rt_value;
            ex_store_data_d = rt_value;
            ex_dst_d        = id_dst;
            ex_reg_write_d  = id_valid && id_reg_write;
            ex_mem_read_d   = id_valid && id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q      <= 1'b0;
            ex_op_a_q       <= '0;
            ex_op_b_q       <= '0;
            ex_store_data_q <= '0;
            ex_dst_q        <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_op_a_q       <= ex_op_a_d;
            ex_op_b_q       <= ex_op_b_d;
            ex_store_data_q <= ex_store_data_d;
            ex_dst_q        <= ex_dst_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_op_a       = ex_op_a_q;
    assign ex_op_b       = ex_op_b_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_dst        = ex_dst_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: forwarding, load-use bubble,
// flush/hold priority, counter saturation and asynchronous reset.
module tb_id_ex_operand_stage;

    localparam int SCW = 2;

    logic           clk;
    logic           reset;
    logic           id_valid, id_reg_write, id_mem_read, id_use_imm;
    logic [4:0]     id_rs, id_rt, id_dst;
    logic [31:0]    id_imm;
    logic [4:0]     rf_raddr1, rf_raddr2;
    logic [31:0]    rf_rdata1, rf_rdata2;
    logic           mem_reg_write;
    logic [4:0]     mem_dst;
    logic [31:0]    mem_data;
    logic           wb_reg_write;
    logic [4:0]     wb_dst;
    logic [31:0]    wb_data;
    logic           ex_flush, ex_hold;
    logic           ex_valid;
    logic [31:0]    ex_op_a, ex_op_b, ex_store_data;
    logic [4:0]     ex_dst;
    logic           ex_reg_write, ex_mem_read;
    logic           id_stall;
    logic [SCW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    id_ex_operand_stage #(.STALL_CNT_W(SCW)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_use_imm    (id_use_imm),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_dst        (id_dst),
        .id_imm        (id_imm),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .ex_flush      (ex_flush),
        .ex_hold       (ex_hold),
        .ex_valid      (ex_valid),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_store_data (ex_store_data),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .id_stall      (id_stall),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string what);
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d %s: ex_valid=%0b op_a=0x%0h op_b=0x%0h st=0x%0h dst=%0d rw=%0b mr=%0b stall=%0b cnt=%0d",
                 cycle, what, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_dst,
                 ex_reg_write, ex_mem_read, id_stall, stall_count);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_use_imm = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_imm = 0;
        rf_rdata1 = 0; rf_rdata2 = 0;
        mem_reg_write = 0; mem_dst = 0; mem_data = 0;
        wb_reg_write = 0; wb_dst = 0; wb_data = 0;
        ex_flush = 0; ex_hold = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_op_a"}, ex_op_a, 32'd0);
        chk({tag, "_op_b"}, ex_op_b, 32'd0);
        chk({tag, "_store"}, ex_store_data, 32'd0);
        chk({tag, "_dst"}, {27'd0, ex_dst}, 32'd0);
        chk({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
        chk({tag, "_mr"}, {31'd0, ex_mem_read}, 32'd0);
        chk({tag, "_cnt"}, {30'd0, stall_count}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #23;
        chk_all_zero("reset");
        reset = 1'b1;

        // WB-to-ID bypass while the register file still returns the old value
        id_valid = 1; id_reg_write = 1; id_rs = 5; id_rt = 6; id_dst = 7;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h66;
        wb_reg_write = 1; wb_dst = 5; wb_data = 32'h1234;
        #1;
        chk("raddr1", {27'd0, rf_raddr1}, 32'd5);
        chk("raddr2", {27'd0, rf_raddr2}, 32'd6);
        step("wb_fwd");
        chk("wb_fwd_op_a", ex_op_a, 32'h1234);
        chk("wb_fwd_op_b", ex_op_b, 32'h66);
        chk("wb_fwd_store", ex_store_data, 32'h66);
        chk("wb_fwd_dst", {27'd0, ex_dst}, 32'd7);
        chk("wb_fwd_valid", {31'd0, ex_valid}, 32'd1);
        chk("wb_fwd_rw", {31'd0, ex_reg_write}, 32'd1);

        // MEM beats WB; immediate replaces op_b but store data stays forwarded rt
        mem_reg_write = 1; mem_dst = 5; mem_data = 32'hAAAA;
        wb_reg_write = 1; wb_dst = 5; wb_data = 32'hBBBB;
        id_rt = 5; id_use_imm = 1; id_imm = 32'h10;
        step("mem_prio");
        chk("mem_prio_op_a", ex_op_a, 32'hAAAA);
        chk("mem_prio_op_b_imm", ex_op_b, 32'h10);
        chk("mem_prio_store", ex_store_data, 32'hAAAA);

        // Register zero is never forwarded
        id_use_imm = 0; id_rs = 0; id_rt = 3;
        rf_rdata1 = 32'h9999; rf_rdata2 = 32'h33;
        mem_reg_write = 1; mem_dst = 0; mem_data = 32'hFFFF;
        wb_reg_write = 1; wb_dst = 0; wb_data = 32'hEEEE;
        step("r0");
        chk("r0_op_a", ex_op_a, 32'h0);
        chk("r0_op_b", ex_op_b, 32'h33);

        // Load-use: lw r8 then add using r8
        idle_inputs();
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_dst = 8; id_rs = 1;
        rf_rdata1 = 32'h100;
        step("lw");
        chk("lw_mr", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_dst", {27'd0, ex_dst}, 32'd8);
        id_mem_read = 0; id_rs = 8; id_rt = 2; id_dst = 9; rf_rdata1 = 32'h0;
        #1;
        chk("lu_stall", {31'd0, id_stall}, 32'd1);
        step("bubble");
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("bubble_mr", {31'd0, ex_mem_read}, 32'd0);
        chk("bubble_cnt", {30'd0, stall_count}, 32'd1);
        chk("bubble_stall_clear", {31'd0, id_stall}, 32'd0);
        mem_reg_write = 1; mem_dst = 8; mem_data = 32'h55;
        step("lu_fwd");
        chk("lu_fwd_op_a", ex_op_a, 32'h55);
        chk("lu_fwd_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_fwd_dst", {27'd0, ex_dst}, 32'd9);
        chk("lu_fwd_cnt", {30'd0, stall_count}, 32'd1);

        // Three more hazards: counter goes 2, 3, then saturates at 3
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_dst = 12;
            step("lw_sat");
            id_mem_read = 0; id_rt = 12; id_dst = 13;
            step("bubble_sat");
            chk("sat_bubble_valid", {31'd0, ex_valid}, 32'd0);
            chk("sat_cnt", {30'd0, stall_count}, (k < 2) ? 32'(k + 2) : 32'd3);
        end

        // Flush wins over hold
        idle_inputs();
        id_valid = 1; id_reg_write = 1; id_rs = 4; rf_rdata1 = 32'h44; id_dst = 10;
        step("load_pre");
        ex_flush = 1; ex_hold = 1;
        step("flush_hold");
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("flush_cnt", {30'd0, stall_count}, 32'd3);
        ex_flush = 0; ex_hold = 0;
        step("reload");
        chk("reload_op_a", ex_op_a, 32'h44);
        chk("reload_valid", {31'd0, ex_valid}, 32'd1);

        // Hold freezes the stage for three cycles
        ex_hold = 1; id_rs = 6; rf_rdata1 = 32'h77; id_dst = 11;
        for (int k = 0; k < 3; k++) begin
            step("hold");
            chk("hold_op_a", ex_op_a, 32'h44);
            chk("hold_dst", {27'd0, ex_dst}, 32'd10);
            chk("hold_valid", {31'd0, ex_valid}, 32'd1);
            chk("hold_stall", {31'd0, id_stall}, 32'd1);
        end

        // Asynchronous reset mid-hold, checked before the next edge
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #3;
        reset = 1'b1;
        ex_hold = 0;
        step("post_rst");
        chk("post_rst_op_a", ex_op_a, 32'h77);
        chk("post_rst_dst", {27'd0, ex_dst}, 32'd11);
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of saturating load-use stall counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_valid, id_reg_write, id_mem_read, id_use_imm  input  1 each  decoded control of instruction in ID.
REQ-005 SHALL have ports id_rs, id_rt, id_dst  input  5 each  source/destination register numbers; id_imm  input  32  extended immediate.
REQ-006 SHALL have ports rf_raddr1, rf_raddr2  output  5  register-file read addresses; rf_rdata1, rf_rdata2  input  32  register-file read data.
REQ-007 SHALL have ports mem_reg_write  input  1, mem_dst  input  5, mem_data  input  32  MEM-stage result for forwarding.
REQ-008 SHALL have ports wb_reg_write  input  1, wb_dst  input  5, wb_data  input  32  WB-stage write (same signals drive register-file write port).
REQ-009 SHALL have ports ex_flush  input  1 (branch/jump squash) and ex_hold  input  1 (EX busy, freeze).
REQ-010 SHALL have outputs ex_valid 1, ex_op_a 32, ex_op_b 32, ex_store_data 32, ex_dst 5, ex_reg_write 1, ex_mem_read 1  registered ID/EX contents.
REQ-011 SHALL have outputs id_stall  1  (combinational, freezes PC and IF/ID) and stall_count  STALL_CNT_W.

Function
REQ-012 SHALL drive rf_raddr1 = id_rs, rf_raddr2 = id_rt combinationally.
REQ-013 SHALL forward operand A from: register 0 -> 0; else MEM match (mem_reg_write, mem_dst==id_rs) -> mem_data; else WB match -> wb_data; else rf_rdata1.
REQ-014 SHALL forward operand B (rt value) identically using id_rt and rf_rdata2; MEM SHALL beat WB when both match.
REQ-015 SHALL never forward when destination is register 0, even with reg_write set.
REQ-016 SHALL select ex_op_b = id_imm when id_use_imm=1, else forwarded rt; ex_store_data SHALL always be forwarded rt.
REQ-017 SHALL assert id_stall when ex_valid & ex_mem_read & ex_dst!=0 & id_valid & (ex_dst==id_rs | ex_dst==id_rt), and also whenever ex_hold=1.
REQ-018 SHALL, per edge, apply priority: ex_flush -> ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; else ex_hold -> all ID/EX registers keep value; else load-use stall -> bubble (ex_valid, ex_reg_write, ex_mem_read <=0); else load ID values.
REQ-019 SHALL load ex_valid=id_valid and gate ex_reg_write/ex_mem_read with id_valid so invalid slots never write.
REQ-020 SHALL incur exactly one bubble per load-use hazard; the following cycle SHALL obtain the load data via MEM forwarding.
REQ-021 SHALL increment stall_count once per load-use bubble cycle (not hold, not flush), saturating at all-ones.
REQ-022 SHALL have latency one cycle ID->EX; forwarding muxes SHALL be purely combinational, no extra cycle.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear every output register to 0: ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_dst, ex_reg_write, ex_mem_read, stall_count.
REQ-024 SHALL, on reset assertion mid-stall or mid-hold, discard the pending instruction; first post-reset edge loads ID normally.

Structure
REQ-025 SHALL take REG_ZERO, register-number width (5), data width (32) and forward-select encoding (FWD_RF, FWD_MEM, FWD_WB, FWD_ZERO) from shared package mips_pipe_pkg.
REQ-026 SHALL instantiate sub-module operand_fwd_mux twice (rs and rt), computing select and forwarded value.

Verification
REQ-027 SHALL cover: WB writes r5=0x1234 while ID reads rs=5, rf_rdata1=old 0x0 -> next edge ex_op_a=0x1234.
REQ-028 SHALL cover: MEM dst=5 data=0xAAAA and WB dst=5 data=0xBBBB, ID rs=5 -> ex_op_a=0xAAAA.
REQ-029 SHALL cover: lw r8 in EX (ex_mem_read=1, ex_dst=8), ID add rs=8 -> id_stall=1 one cycle, ex_valid=0 bubble, stall_count 0->1; next cycle lw in MEM, mem_data=0x55 -> ex_op_a=0x55.
REQ-030 SHALL cover: mem_dst=0, mem_reg_write=1, mem_data=0xFFFF, ID rs=0 -> ex_op_a=0.
REQ-031 SHALL cover: ex_flush and ex_hold both 1 with valid ID -> ex_valid=0, ex_reg_write=0; ex_hold alone for 3 cycles -> outputs unchanged, id_stall=1.
REQ-032 SHALL cover: reset pulled low mid-hold with ex_valid=1 -> all outputs 0 immediately, before next clk edge.
